vga_text_controller: RTL and testbench
======================================

Name: vga_text_controller

Overview:
- Sequences the VGA letters datapath for a 640x480@60 text display: 80x30 cells of 8x16 glyphs.
- Generates pixel timing and fetches character codes from text RAM, then glyph rows from font ROM.
- Produces the 3-bit colour code consumed by the RGB decoder, plus sync and blank signals aligned to that code.
- Sits between the 50 MHz system clock domain and the VGA DAC path.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick; legal values are 2 or more.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- COLS, 80, text columns.
- BLINK_FRAMES, 30, frames per cursor blink phase.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_addr  out  12  text RAM address, row*COLS+col, range 0..2399.
- char_data  in  8  character code; synchronous RAM, valid one clk after address.
- font_addr  out  12  font ROM address, {char_code, glyph_row[3:0]}.
- font_data  in  8  glyph row; bit 7 is the leftmost pixel; synchronous ROM, valid one clk after address.
- cursor_col  in  7  cursor column, 0..79.
- cursor_row  in  5  cursor row, 0..29.
- cursor_en  in  1  enables the blinking cursor.
- color  out  3  colour code to the decoder: 3'b000 background, 3'b111 letter.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- blank_n  out  1  high during the visible region.
- frame_start  out  1  one-clk pulse when the frame counter wraps to (0,0).

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - counters, divider, blink counter and blink phase are all 0;
  - char_addr=0, font_addr=0;
  - color=3'b000, hsync=1, vsync=1, blank_n=0, frame_start=0.
- Pixel tick: an internal divider counts 0..CLK_DIV-1; tick is asserted when it reaches CLK_DIV-1. All pipeline and counter registers update only on tick.
- Counters:
  - hcount runs 0..799 (H_ACTIVE+H_FP+H_SYNC+H_BP-1) and wraps to 0.
  - vcount increments when hcount wraps; it runs 0..524 and wraps to 0.
- Raw timing, computed from the counters:
  - active = (hcount<640) && (vcount<480).
  - hs_raw is low for hcount in 656..751.
  - vs_raw is low for vcount in 490..491.
- Pipeline (tick t holds counter value P):
  - Stage 1, registered at tick t: char_addr = (vcount>>4)*80 + (hcount>>3). Carry forward hcount[2:0], vcount[3:0], active, hs_raw, vs_raw, and cursor_hit.
  - Stage 2, registered at tick t+1: font_addr = {char_data, vcount_lo}; forward the remaining signals.
  - Stage 3, registered at tick t+2: pixel = font_data[7-hcount_lo].
- cursor_hit is true when cursor_en is set, the cell matches cursor_col/cursor_row, glyph row is 14 or 15, and blink_phase=1.
- Colour at stage 3:
  - color = 3'b111 if active && (pixel || cursor_hit);
  - otherwise color = 3'b000;
  - outside the active region color is always 3'b000.
- Output alignment: hsync, vsync and blank_n are registered in stage 3 alongside color. All four outputs lag the counter position by exactly 3 ticks.
- Blink: blink_cnt increments on each frame wrap. At BLINK_FRAMES-1 it resets to 0 and blink_phase toggles.
- frame_start is asserted for the single clk in which the tick moves the counters from (799,524) to (0,0).
- Mid-frame cursor changes: cursor_col, cursor_row and cursor_en are sampled at stage 1. A change takes effect on the next pixel; no glitch suppression is applied.
- Out-of-range cursor (col>79 or row>29): the cursor never matches, so nothing is drawn.
- Memory timing: CLK_DIV>=2 guarantees memory data is valid at the next tick. Address outputs hold between ticks.

Decomposition:
- Package vga_text_pkg holds:
  - timing constants H_TOTAL=800, V_TOTAL=525, and the sync start/end values;
  - CHAR_W=8, CHAR_H=16;
  - COLOR_BG=3'b000, COLOR_FG=3'b111.
- Sub-module vga_timing_gen owns the divider, hcount, vcount, active, hs_raw, vs_raw and frame_start.
- The top level contains the fetch pipeline, cursor logic and blink logic.

Test Plan:
- Reset mid-frame (rst_n low at hcount=300), then release.
  - Expect color=000, hsync=1, vsync=1, blank_n=0 immediately.
  - Counters restart at (0,0); first frame_start arrives 800*525*2 clks after release.
- Timing check over one frame.
  - hsync low for exactly 96 ticks, starting 659 ticks after hcount=0 (656 plus 3 ticks of lag).
  - vsync low for 2 lines; blank_n high for 640 ticks per line on 480 lines.
- Glyph fetch: text RAM cell 0 holds 0x41; font ROM row 0 of 0x41 holds 8'b0001_1000.
  - At pixel (0,0): char_addr=0, then font_addr=0x410.
  - Colour sequence for x=0..7 is 000,000,000,111,111,000,000,000, starting 3 ticks after hcount=0.
- Addressing at the last cell: pixel (639,479).
  - char_addr=2399 and font_addr low nibble=15.
  - At hcount=640 (lagged by 3), color=000 regardless of font_data=8'hFF.
- Cursor: cursor_en=1 at (col 5,row 2) with blank text.
  - Rows 46..47, x 40..47 show 111 while blink_phase=1.
  - They show 000 during the next 30 frames after the toggle.
- Out-of-range cursor_col=100 with cursor_en=1: no cursor pixels over 2 blink periods.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the 80x30 VGA text controller: reference 640x480@60
// timing, glyph cell geometry and the two colour codes.
package vga_text_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [2:0] COLOR_BG = 3'b000;
  localparam logic [2:0] COLOR_FG = 3'b111;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical counters. Produces the raw
// (unpipelined) active/sync flags and the frame wrap strobe.
module vga_timing_gen
  import vga_text_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = H_SYNC_START - 640,
  parameter int H_SYNC   = H_SYNC_END - H_SYNC_START + 1,
  parameter int H_BP     = H_TOTAL - 1 - H_SYNC_END,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = V_SYNC_START - 480,
  parameter int V_SYNC   = V_SYNC_END - V_SYNC_START + 1,
  parameter int V_BP     = V_TOTAL - 1 - V_SYNC_END
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_wrap,
  output logic       frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             h_wrap;
  logic             v_wrap;

  assign tick       = (div_cnt == DIV_LAST);
  assign h_wrap     = (hcount == H_LAST);
  assign v_wrap     = (vcount == V_LAST);
  assign frame_wrap = tick && h_wrap && v_wrap;

  assign active = (hcount < H_VIS) && (vcount < V_VIS);
  assign hs_raw = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
  assign vs_raw = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));

  // System-clock divider: one pixel tick every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster position; vcount advances only when the line wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hcount <= '0;
        vcount <= v_wrap ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // One-clock pulse in the clock where the counters first read (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: rtl/vga_text_controller.sv
// Text-mode VGA controller: three-tick fetch pipeline (text RAM -> font ROM
// -> pixel select), blinking underline cursor and sync/blank alignment.
module vga_text_controller
  import vga_text_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_en,
  output logic [2:0]  color,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int CW_BITS = $clog2(CHAR_W);
  localparam int CH_BITS = $clog2(CHAR_H);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [11:0] COLS_A   = 12'(COLS);
  localparam logic [6:0]  COLS_C   = 7'(COLS);
  localparam logic [5:0]  ROWS_C   = 6'(V_ACTIVE / CHAR_H);
  localparam logic [3:0]  UL_FIRST = 4'(CHAR_H - 2);

  logic       tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic       frame_wrap;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .hcount      (hcount),
    .vcount      (vcount),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_wrap  (frame_wrap),
    .frame_start (frame_start)
  );

  logic [6:0]         cell_col;
  logic [5:0]         cell_row;
  logic [3:0]         glyph_row;
  logic [2:0]         pix_col;
  logic [11:0]        cell_addr;
  logic               cursor_hit;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  assign cell_col  = 7'(hcount >> CW_BITS);
  assign cell_row  = 6'(vcount >> CH_BITS);
  assign glyph_row = vcount[3:0];
  assign pix_col   = hcount[2:0];
  assign cell_addr = {6'd0, cell_row} * COLS_A + {5'd0, cell_col};

  // Underline cursor: bottom two glyph rows of the selected cell, lit only
  // in the "on" blink phase. Out-of-range cursor positions never match.
  assign cursor_hit = cursor_en && blink_phase
                      && (cursor_col < COLS_C) && ({1'b0, cursor_row} < ROWS_C)
                      && (cell_col == cursor_col) && (cell_row == {1'b0, cursor_row})
                      && (glyph_row >= UL_FIRST);

  // Blink phase flips every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [2:0] s1_hlo;
  logic [3:0] s1_vlo;
  logic       s1_active;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_cursor;

  // Stage 1: issue the text RAM address and capture the per-pixel context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= '0;
      s1_hlo    <= '0;
      s1_vlo    <= '0;
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_cursor <= 1'b0;
    end else if (tick) begin
      char_addr <= cell_addr;
      s1_hlo    <= pix_col;
      s1_vlo    <= glyph_row;
      s1_active <= active;
      s1_hs     <= hs_raw;
      s1_vs     <= vs_raw;
      s1_cursor <= cursor_hit;
    end
  end

  logic [2:0] s2_hlo;
  logic       s2_active;
  logic       s2_hs;
  logic       s2_vs;
  logic       s2_cursor;

  // Stage 2: character code is back from text RAM; issue the font ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_addr <= '0;
      s2_hlo    <= '0;
      s2_active <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      s2_cursor <= 1'b0;
    end else if (tick) begin
      font_addr <= {char_data, s1_vlo};
      s2_hlo    <= s1_hlo;
      s2_active <= s1_active;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_cursor <= s1_cursor;
    end
  end

  // Stage 3: pick the glyph bit (bit 7 leftmost) and register all outputs together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color   <= COLOR_BG;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else if (tick) begin
      color   <= (s2_active && (font_data[3'd7 - s2_hlo] || s2_cursor)) ? COLOR_FG : COLOR_BG;
      hsync   <= s2_hs;
      vsync   <= s2_vs;
      blank_n <= s2_active;
    end
  end

endmodule

// File: tb/tb_vga_text_controller.sv
// Self-checking bench for vga_text_controller on a shrunken raster (6x3 cells)
// so that many frames and blink periods fit in a short run. A reference model
// walks the raster and queues expected outputs; they are compared when the
// DUT's pipeline delivers them.
module tb_vga_text_controller;

  localparam int CLK_DIV = 2;
  localparam int HA  = 48;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 2;
  localparam int VA  = 48;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int COLS  = 6;
  localparam int BLINK = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic [2:0]  color;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        frame_start;

  vga_text_controller #(
    .CLK_DIV      (CLK_DIV),
    .H_ACTIVE     (HA),
    .H_FP         (HFP),
    .H_SYNC       (HSW),
    .H_BP         (HBP),
    .V_ACTIVE     (VA),
    .V_FP         (VFP),
    .V_SYNC       (VSW),
    .V_BP         (VBP),
    .COLS         (COLS),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_addr   (char_addr),
    .char_data   (char_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .cursor_en   (cursor_en),
    .color       (color),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .frame_start (frame_start)
  );

  // Synchronous text RAM and font ROM.
  logic [7:0] text_ram [4096];
  logic [7:0] font_rom [4096];
  always @(posedge clk) begin
    char_data <= text_ram[char_addr];
    font_data <= font_rom[font_addr];
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [5:0]  exp_q[$];   // {color, hsync, vsync, blank_n}
  logic [11:0] font_q[$];
  int   edges;             // clocks since reset release
  int   mh, mv, mf;        // model raster position and frame number
  int   cap_col, cap_row;
  logic cap_en;

  // Count clocks and capture cursor inputs as the DUT sees them at the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0;
    end else begin
      edges   = edges + 1;
      cap_col = int'(cursor_col);
      cap_row = int'(cursor_row);
      cap_en  = cursor_en;
    end
  end

  int          m_addr, m_code, m_col, m_row, m_lo;
  logic [7:0]  m_glyph;
  logic        m_tick, m_wrap, m_act, m_pix, m_cur, m_hs, m_vs, m_phase;
  logic [2:0]  m_color;
  logic [5:0]  m_exp;
  logic [11:0] m_fexp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mh = 0; mv = 0; mf = 0;
      exp_q.delete();
      font_q.delete();
    end else if (edges > 0) begin
      m_tick = (edges % CLK_DIV) == 0;
      m_wrap = m_tick && (mh == HT - 1) && (mv == VT - 1);
      check("frame_start", frame_start, m_wrap);
      if (m_tick) begin
        m_col   = mh / 8;
        m_row   = mv / 16;
        m_lo    = mv % 16;
        m_addr  = m_row * COLS + m_col;
        m_code  = int'(text_ram[m_addr]);
        m_glyph = font_rom[m_code * 16 + m_lo];
        m_act   = (mh < HA) && (mv < VA);
        m_pix   = m_glyph[7 - (mh % 8)];
        m_phase = ((mf / BLINK) % 2) == 1;
        m_cur   = cap_en && m_phase && (cap_col < COLS) && (cap_row < VA / 16)
                  && (cap_col == m_col) && (cap_row == m_row) && (m_lo >= 14);
        m_color = (m_act && (m_pix || m_cur)) ? 3'b111 : 3'b000;
        m_hs    = !((mh >= HA + HFP) && (mh < HA + HFP + HSW));
        m_vs    = !((mv >= VA + VFP) && (mv < VA + VFP + VSW));
        check("char_addr", char_addr, m_addr);
        font_q.push_back(12'(m_code * 16 + m_lo));
        exp_q.push_back({m_color, m_hs, m_vs, m_act});
        if (font_q.size() == 2) begin
          m_fexp = font_q.pop_front();
          check("font_addr", font_addr, m_fexp);
        end
        if (exp_q.size() == 3) begin
          m_exp = exp_q.pop_front();
          check("color",   color,   m_exp[5:3]);
          check("hsync",   hsync,   m_exp[2]);
          check("vsync",   vsync,   m_exp[1]);
          check("blank_n", blank_n, m_exp[0]);
        end
        if (mh == HT - 1) begin
          mh = 0;
          if (mv == VT - 1) begin
            mv = 0;
            mf = mf + 1;
          end else begin
            mv = mv + 1;
          end
        end else begin
          mh = mh + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input int target);
    int n = 0;
    while (mf < target && n < (target + 2) * FRAME_CLKS) begin
      @(posedge clk);
      n++;
    end
    check("frame_reached", mf, target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin
      text_ram[i] = 8'($urandom_range(0, 255));
      font_rom[i] = 8'($urandom_range(0, 255));
    end
    text_ram[0]       = 8'h41;
    font_rom[12'h410] = 8'h18;
    text_ram[2 * COLS + 5] = 8'h20;
    for (int r = 0; r < 16; r++) font_rom[12'h200 + r] = 8'h00;
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Run into the middle of the frame, then reset asynchronously.
    n = 0;
    while (!(mv == 20 && mh == 10) && n < FRAME_CLKS) begin
      @(posedge clk);
      n++;
    end
    check("mid_frame_reached", mv * 1000 + mh, 20 * 1000 + 10);
    @(posedge clk);
    #1;
    check("pre_reset_blank_n", blank_n, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_color",       color,       3'b000);
    check("rst_hsync",       hsync,       1'b1);
    check("rst_vsync",       vsync,       1'b1);
    check("rst_blank_n",     blank_n,     1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_char_addr",   char_addr,   12'd0);
    check("rst_font_addr",   font_addr,   12'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First frame_start must arrive exactly one frame of clocks after release.
    n = 0;
    while (n < FRAME_CLKS + 10) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    check("first_frame_start_clks", edges, FRAME_CLKS);

    // In-range cursor across three blink phases (off, on, off).
    wait_frame(6);
    @(posedge clk);
    #1 cursor_col = 7'd100;
    // Out-of-range cursor over two full blink periods.
    wait_frame(10);
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
